// File: rtl/box_draw_controller.sv
// ---------------------------------------------------------------------------
// box_draw_controller
//   Draw-control FSM for the VGA pixel path. A go request latches a base
//   (x,y), a colour and an erase flag. A start request then walks a
//   BOX_W x BOX_H rectangle one pixel per clock, strobing writeEn for each
//   pixel. Abort cancels either the pending load or the draw in progress.
//
// Ports
//   clock          system clock, all state changes on posedge
//   reset          synchronous active-high reset, overrides every input
//   go             load request (accepted only when idle)
//   start_drawing  start request (accepted only while waiting after a load)
//   abort          cancel the pending load or the running draw
//   erase          0 = draw colour_in, 1 = draw colour 0
//   x_in, y_in     base coordinate of the rectangle
//   colour_in      fill colour
//   x_out, y_out   pixel coordinate to the adapter (wraps mod 2^width)
//   colour_out     pixel colour to the adapter
//   writeEn        pixel write strobe, one pixel per high cycle
//   busy           high while waiting for start or drawing
//   done           one-cycle pulse after the last pixel of a completed box
//
// All outputs are registers loaded from the next-state values, so they
// show the same cycle timing as a decode of the current state.
// ---------------------------------------------------------------------------
module box_draw_controller #(
   parameter int X_BITS      = 8,
   parameter int Y_BITS      = 7,
   parameter int COLOUR_BITS = 3,
   parameter int BOX_W       = 4,
   parameter int BOX_H       = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   go,
   input  logic                   start_drawing,
   input  logic                   abort,
   input  logic                   erase,
   input  logic [X_BITS-1:0]      x_in,
   input  logic [Y_BITS-1:0]      y_in,
   input  logic [COLOUR_BITS-1:0] colour_in,
   output logic [X_BITS-1:0]      x_out,
   output logic [Y_BITS-1:0]      y_out,
   output logic [COLOUR_BITS-1:0] colour_out,
   output logic                   writeEn,
   output logic                   busy,
   output logic                   done
);

   localparam int CX_W = $clog2(BOX_W) + 1;
   localparam int CY_W = $clog2(BOX_H) + 1;
   localparam logic [CX_W-1:0] CX_LAST = CX_W'(BOX_W - 1);
   localparam logic [CY_W-1:0] CY_LAST = CY_W'(BOX_H - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LOAD_WAIT = 2'd1,
      S_DRAW      = 2'd2,
      S_DONE      = 2'd3
   } state_t;

   state_t                 state_r;
   state_t                 next_state_s;
   logic [X_BITS-1:0]      base_x_r;
   logic [Y_BITS-1:0]      base_y_r;
   logic [COLOUR_BITS-1:0] colour_r;
   logic                   erase_r;
   logic [CX_W-1:0]        cx_r;
   logic [CY_W-1:0]        cy_r;
   logic [CX_W-1:0]        cx_next_s;
   logic [CY_W-1:0]        cy_next_s;
   logic                   load_s;

   logic [X_BITS-1:0]      x_out_r;
   logic [Y_BITS-1:0]      y_out_r;
   logic [COLOUR_BITS-1:0] colour_out_r;
   logic                   write_en_r;
   logic                   busy_r;
   logic                   done_r;

   // Next-state, pixel-stepping and load-enable decode.
   always_comb begin
      next_state_s = state_r;
      cx_next_s    = cx_r;
      cy_next_s    = cy_r;
      load_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (go) begin
               load_s       = 1'b1;
               next_state_s = S_LOAD_WAIT;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_LOAD_WAIT: begin
            if (abort) begin
               next_state_s = S_IDLE;
            end else if (start_drawing) begin
               cx_next_s    = {CX_W{1'b0}};
               cy_next_s    = {CY_W{1'b0}};
               next_state_s = S_DRAW;
            end else begin
               next_state_s = S_LOAD_WAIT;
            end
         end
         S_DRAW: begin
            if (cx_r == CX_LAST) begin
               cx_next_s = {CX_W{1'b0}};
               if (cy_r == CY_LAST) begin
                  next_state_s = S_DONE;
               end else begin
                  cy_next_s = cy_r + CY_W'(1);
               end
            end else begin
               cx_next_s = cx_r + CX_W'(1);
            end
            // Abort still lets this cycle's pixel through; it only
            // redirects the next state, so done is never reached.
            if (abort) begin
               next_state_s = S_IDLE;
            end else begin
               next_state_s = next_state_s;
            end
         end
         S_DONE: begin
            next_state_s = S_IDLE;
         end
         default: begin
            next_state_s = S_IDLE;
         end
      endcase
   end

   // State, latched parameters, pixel counters and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= S_IDLE;
         base_x_r     <= {X_BITS{1'b0}};
         base_y_r     <= {Y_BITS{1'b0}};
         colour_r     <= {COLOUR_BITS{1'b0}};
         erase_r      <= 1'b0;
         cx_r         <= {CX_W{1'b0}};
         cy_r         <= {CY_W{1'b0}};
         x_out_r      <= {X_BITS{1'b0}};
         y_out_r      <= {Y_BITS{1'b0}};
         colour_out_r <= {COLOUR_BITS{1'b0}};
         write_en_r   <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r <= next_state_s;
         cx_r    <= cx_next_s;
         cy_r    <= cy_next_s;
         if (load_s) begin
            base_x_r <= x_in;
            base_y_r <= y_in;
            colour_r <= colour_in;
            erase_r  <= erase;
         end
         // Base registers only change in S_IDLE, so they are stable
         // whenever the next state is S_DRAW.
         if (next_state_s == S_DRAW) begin
            x_out_r      <= base_x_r + X_BITS'(cx_next_s);
            y_out_r      <= base_y_r + Y_BITS'(cy_next_s);
            colour_out_r <= erase_r ? {COLOUR_BITS{1'b0}} : colour_r;
            write_en_r   <= 1'b1;
         end else begin
            x_out_r      <= {X_BITS{1'b0}};
            y_out_r      <= {Y_BITS{1'b0}};
            colour_out_r <= {COLOUR_BITS{1'b0}};
            write_en_r   <= 1'b0;
         end
         busy_r <= (next_state_s == S_LOAD_WAIT) || (next_state_s == S_DRAW);
         done_r <= (next_state_s == S_DONE);
      end
   end

   assign x_out      = x_out_r;
   assign y_out      = y_out_r;
   assign colour_out = colour_out_r;
   assign writeEn    = write_en_r;
   assign busy       = busy_r;
   assign done       = done_r;

endmodule

// File: tb/tb_box_draw_controller.sv
// ---------------------------------------------------------------------------
// tb_box_draw_controller
//   Directed bench for box_draw_controller with the default 4x4 box.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   that same point, i.e. they reflect the state entered at that edge.
// ---------------------------------------------------------------------------
module tb_box_draw_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic       go;
   logic       start_drawing;
   logic       abort;
   logic       erase;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [2:0] colour_in;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;
   logic       writeEn;
   logic       busy;
   logic       done;

   int tests = 0;
   int fails = 0;

   box_draw_controller dut (
      .clock         (clock),
      .reset         (reset),
      .go            (go),
      .start_drawing (start_drawing),
      .abort         (abort),
      .erase         (erase),
      .x_in          (x_in),
      .y_in          (y_in),
      .colour_in     (colour_in),
      .x_out         (x_out),
      .y_out         (y_out),
      .colour_out    (colour_out),
      .writeEn       (writeEn),
      .busy          (busy),
      .done          (done)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Outputs expected outside S_DRAW: everything zero apart from busy/done.
   task automatic check_quiet(input string tag, input logic exp_busy,
                              input logic exp_done);
      check({tag, ".we"},     {31'd0, writeEn}, {31'd0, 1'b0});
      check({tag, ".x"},      {24'd0, x_out},   32'd0);
      check({tag, ".y"},      {25'd0, y_out},   32'd0);
      check({tag, ".col"},    {29'd0, colour_out}, 32'd0);
      check({tag, ".busy"},   {31'd0, busy},    {31'd0, exp_busy});
      check({tag, ".done"},   {31'd0, done},    {31'd0, exp_done});
   endtask

   task automatic check_pixel(input string tag, input logic [7:0] ex,
                              input logic [6:0] ey, input logic [2:0] ec);
      check({tag, ".we"},   {31'd0, writeEn},    32'd1);
      check({tag, ".x"},    {24'd0, x_out},      {24'd0, ex});
      check({tag, ".y"},    {25'd0, y_out},      {25'd0, ey});
      check({tag, ".col"},  {29'd0, colour_out}, {29'd0, ec});
      check({tag, ".busy"}, {31'd0, busy},       32'd1);
      check({tag, ".done"}, {31'd0, done},       32'd0);
   endtask

   // go, then start; leaves the bench at the first pixel cycle.
   task automatic load_and_start(input logic [7:0] bx, input logic [6:0] by,
                                 input logic [2:0] col, input logic er);
      go = 1'b1; x_in = bx; y_in = by; colour_in = col; erase = er;
      tick();
      check_quiet("load", 1'b1, 1'b0);
      go = 1'b0; x_in = 8'd0; y_in = 7'd0; colour_in = 3'd0; erase = 1'b0;
      start_drawing = 1'b1;
      tick();
      start_drawing = 1'b0;
   endtask

   // Full 4x4 box with done pulse and return to idle.
   task automatic full_box(input string tag, input logic [7:0] bx,
                           input logic [6:0] by, input logic [2:0] col,
                           input logic er);
      logic [7:0] ex;
      logic [6:0] ey;
      load_and_start(bx, by, col, er);
      for (int i = 0; i < 16; i++) begin
         ex = bx + 8'(i % 4);
         ey = by + 7'(i / 4);
         check_pixel($sformatf("%s.px%0d", tag, i), ex, ey, er ? 3'd0 : col);
         tick();
      end
      check_quiet({tag, ".done_cyc"}, 1'b0, 1'b1);
      tick();
      check_quiet({tag, ".idle"}, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] ex;
      logic [6:0] ey;

      // 1. Reset with go/start held high.
      reset = 1'b1; go = 1'b1; start_drawing = 1'b1; abort = 1'b0;
      erase = 1'b0; x_in = 8'd33; y_in = 7'd44; colour_in = 3'd7;
      tick();
      tick();
      check_quiet("reset", 1'b0, 1'b0);
      reset = 1'b0; go = 1'b0; x_in = 8'd0; y_in = 7'd0; colour_in = 3'd0;
      // start and abort are ignored in idle
      start_drawing = 1'b1; abort = 1'b1;
      tick();
      check_quiet("idle_ign", 1'b0, 1'b0);
      start_drawing = 1'b0; abort = 1'b0;

      // 2. Basic draw.
      full_box("draw", 8'd10, 7'd20, 3'd5, 1'b0);

      // 3. Erase draw.
      full_box("erase", 8'd10, 7'd20, 3'd5, 1'b1);

      // 4. x wrap: 254,255,0,1 on each row.
      full_box("wrap", 8'd254, 7'd3, 3'd2, 1'b0);

      // go ignored while waiting, abort while waiting returns to idle.
      go = 1'b1; x_in = 8'd50; y_in = 7'd60; colour_in = 3'd6;
      tick();
      x_in = 8'd99; y_in = 7'd99; colour_in = 3'd1;
      tick();
      check_quiet("wait_hold", 1'b1, 1'b0);
      go = 1'b0; start_drawing = 1'b1;
      tick();
      start_drawing = 1'b0;
      check_pixel("wait_latched", 8'd50, 7'd60, 3'd6);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_quiet("abort_first", 1'b0, 1'b0);

      go = 1'b1; x_in = 8'd1; y_in = 7'd2; colour_in = 3'd3;
      tick();
      go = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      check_quiet("abort_wait", 1'b0, 1'b0);
      tick();
      check_quiet("abort_wait2", 1'b0, 1'b0);

      // 5. Abort on the 6th write cycle.
      load_and_start(8'd40, 7'd30, 3'd4, 1'b0);
      for (int i = 0; i < 6; i++) begin
         ex = 8'd40 + 8'(i % 4);
         ey = 7'd30 + 7'(i / 4);
         check_pixel($sformatf("abort.px%0d", i), ex, ey, 3'd4);
         if (i == 5) abort = 1'b1;
         tick();
      end
      abort = 1'b0;
      check_quiet("abort.after", 1'b0, 1'b0);
      tick();
      check_quiet("abort.after2", 1'b0, 1'b0);

      // 6. Reset mid-draw, then a full box.
      load_and_start(8'd70, 7'd80, 3'd7, 1'b0);
      check_pixel("rst.px0", 8'd70, 7'd80, 3'd7);
      tick();
      check_pixel("rst.px1", 8'd71, 7'd80, 3'd7);
      tick();
      check_pixel("rst.px2", 8'd72, 7'd80, 3'd7);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_quiet("rst.mid", 1'b0, 1'b0);
      full_box("post_rst", 8'd10, 7'd20, 3'd5, 1'b0);

      // go held across the done cycle is taken in the following idle cycle.
      load_and_start(8'd0, 7'd0, 3'd1, 1'b0);
      for (int i = 0; i < 16; i++) tick();
      go = 1'b1; x_in = 8'd5; y_in = 7'd6; colour_in = 3'd2;
      check_quiet("hold.done", 1'b0, 1'b1);
      tick();
      check_quiet("hold.idle", 1'b0, 1'b0);
      tick();
      check_quiet("hold.load", 1'b1, 1'b0);
      go = 1'b0; start_drawing = 1'b1;
      tick();
      start_drawing = 1'b0;
      check_pixel("hold.px0", 8'd5, 7'd6, 3'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
